// File: rtl/gfx_renderer_zq.sv
// gfx_renderer_zq: pixel renderer sitting between the rasteriser and the
// wishbone master. Pixels are queued in a small FIFO, clipped against the
// target extents, optionally depth tested against the z buffer and written
// to memory.
//
// Ports
//   clk_i, rst_i                        clock, synchronous active-high reset
//   target_base_i, zbuffer_base_i       colour / z buffer byte base addresses
//   target_size_x_i, target_size_y_i    clip extents (pixel must be < size)
//   bpp_i, cbpp_i                       bits per pixel in memory / colour bits used
//   coeff1_i                            colour row pitch in bytes
//   coeff2_i                            z row pitch in pixels
//   rmw_i, zbuffer_enable_i, zfunc_i    colour merge, depth test enable, z function
//   pixel_x/y/z_i, color_i, write_i     pixel push interface; full_o back-pressure
//   render_addr/sel/dat_o, render_dat_i bus address (word aligned), lanes, data
//   read_o, write_o, ack_i              bus requests and acknowledge
//   ack_o, discard_o                    one pulse per retired / dropped pixel
//   busy_o                              work queued or in flight
//
// Address generation: colour byte = base + y*coeff1 + x*bpp/8,
// z byte = zbase + (y*coeff2 + x)*point_width/8. The bus address is the
// byte address rounded down to the MDW/8 boundary; the low bits pick lanes.
module gfx_renderer_zq #(
  parameter int point_width = 16,
  parameter int MDW         = 256,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_LAT    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            target_base_i,
  input  logic [31:0]            zbuffer_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  input  logic [5:0]             bpp_i,
  input  logic [5:0]             cbpp_i,
  input  logic [15:0]            coeff1_i,
  input  logic [9:0]             coeff2_i,
  input  logic                   rmw_i,
  input  logic                   zbuffer_enable_i,
  input  logic [1:0]             zfunc_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [31:0]            color_i,
  input  logic                   write_i,
  output logic                   full_o,
  output logic [31:0]            render_addr_o,
  output logic [MDW/8-1:0]       render_sel_o,
  output logic [MDW-1:0]         render_dat_o,
  input  logic [MDW-1:0]         render_dat_i,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   ack_i,
  output logic                   ack_o,
  output logic                   discard_o,
  output logic                   busy_o
);

  // state  | meaning
  // IDLE   | nothing queued
  // POP    | latch FIFO head and controls, clip test
  // ADDR   | wait for address/lane calculation
  // ZREAD  | read stored z
  // ZTEST  | compare new z against stored z
  // CREAD  | read colour word for merging
  // CWRITE | write colour
  // ZWRITE | write new z
  // RETIRE | pulse ack_o (and discard_o)
  typedef enum logic [3:0] {
    IDLE, POP, ADDR, ZREAD, ZTEST, CREAD, CWRITE, ZWRITE, RETIRE
  } state_t;

  localparam int SW   = MDW / 8;
  localparam int OFFW = $clog2(SW);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int FW   = 3 * point_width + 32;
  localparam int ZB   = point_width / 8;
  localparam int LATW = (ADDR_LAT < 1) ? 1 : $clog2(ADDR_LAT + 1);
  localparam logic [PTRW:0]   DEPTH_C  = (PTRW + 1)'(FIFO_DEPTH);
  localparam logic [LATW-1:0] LAT_INIT = LATW'(ADDR_LAT);

  state_t state;

  // ---------------- input FIFO ----------------
  logic [FW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [PTRW:0]   count, count_next;
  logic            push, pop;
  logic [FW-1:0]   head;
  logic [point_width-1:0] head_x, head_y;

  assign push   = write_i & ~full_o;
  assign pop    = (state == POP);
  assign head   = fifo_mem[rd_ptr];
  assign head_x = head[FW-1 -: point_width];
  assign head_y = head[FW-1-point_width -: point_width];

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      full_o <= (count_next == DEPTH_C);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= {pixel_x_i, pixel_y_i, pixel_z_i, color_i};
  end

  assign busy_o = (count != '0) || (state != IDLE);

  // ---------------- per-pixel latches ----------------
  logic [point_width-1:0] px, py, pz, z_old;
  logic [31:0]            pcol, tbase_q, zbase_q, c_byte_q, z_byte_q;
  logic [5:0]             bpp_q, cbpp_q;
  logic [15:0]            c1_q;
  logic [9:0]             c2_q;
  logic                   rmw_q, zen_q;
  logic [1:0]             zfn_q;
  logic [LATW-1:0]        lat_cnt;
  logic [MDW-1:0]         merge_q;

  // ---------------- address and lane generation ----------------
  logic [31:0]            c_byte, z_byte, c_word, z_word, col_m;
  logic [SW-1:0]          pix_sel, lane_sel, z_sel, col_sel;
  logic [MDW-1:0]         bmask, col_raw, col_dat, z_dat;
  logic [point_width-1:0] z_rd;
  logic                   z_pass;
  int                     co, cn, zo;

  assign c_byte = tbase_q + 32'(py) * 32'(c1_q) + ((32'(px) * 32'(bpp_q)) >> 3);
  assign z_byte = zbase_q + (32'(py) * 32'(c2_q) + 32'(px)) * 32'(ZB);
  assign c_word = {c_byte_q[31:OFFW], {OFFW{1'b0}}};
  assign z_word = {z_byte_q[31:OFFW], {OFFW{1'b0}}};

  // Colour is trimmed to its source depth before being placed in the lane.
  assign col_m   = (cbpp_q >= 6'd32) ? pcol : (pcol & ((32'd1 << cbpp_q) - 32'd1));
  assign col_raw = MDW'(col_m) << {c_byte_q[OFFW-1:0], 3'b000};
  assign z_dat   = MDW'(pz) << {z_byte_q[OFFW-1:0], 3'b000};
  assign z_rd    = point_width'(render_dat_i >> {z_byte_q[OFFW-1:0], 3'b000});

  always_comb begin
    co = int'(c_byte_q[OFFW-1:0]);
    cn = int'(bpp_q[5:3]);
    zo = int'(z_byte_q[OFFW-1:0]);
    pix_sel  = '0;
    lane_sel = '0;
    z_sel    = '0;
    bmask    = '0;
    for (int i = 0; i < SW; i++) begin
      pix_sel[i]    = (i >= co) && (i < co + cn);
      lane_sel[i]   = ((i / 4) == (co / 4));
      z_sel[i]      = (i >= zo) && (i < zo + ZB);
      bmask[i*8+:8] = {8{pix_sel[i]}};
    end
  end

  // A merged write covers the whole 32-bit lane holding the pixel, so the
  // bytes around the pixel come back from the preceding colour read.
  assign col_sel = rmw_q ? lane_sel : pix_sel;
  assign col_dat = rmw_q ? ((merge_q & ~bmask) | (col_raw & bmask)) : col_raw;

  always_comb begin
    case (zfn_q)
      2'd0:    z_pass = (pz < z_old);
      2'd1:    z_pass = (pz <= z_old);
      2'd2:    z_pass = 1'b1;
      default: z_pass = 1'b0;
    endcase
  end

  // ---------------- control FSM ----------------
  // Bus states raise the request on entry and drop it on the ack cycle, so
  // address/lanes/data stay frozen for the whole request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      read_o        <= 1'b0;
      write_o       <= 1'b0;
      ack_o         <= 1'b0;
      discard_o     <= 1'b0;
      render_addr_o <= '0;
      render_sel_o  <= '0;
      render_dat_o  <= '0;
    end else begin
      case (state)
        IDLE: if (count != '0) state <= POP;
        POP: begin
          px      <= head_x;
          py      <= head_y;
          pz      <= head[32 +: point_width];
          pcol    <= head[31:0];
          tbase_q <= target_base_i;
          zbase_q <= zbuffer_base_i;
          bpp_q   <= bpp_i;
          cbpp_q  <= cbpp_i;
          c1_q    <= coeff1_i;
          c2_q    <= coeff2_i;
          rmw_q   <= rmw_i;
          zen_q   <= zbuffer_enable_i;
          zfn_q   <= zfunc_i;
          if (head_x >= target_size_x_i || head_y >= target_size_y_i) begin
            ack_o     <= 1'b1;
            discard_o <= 1'b1;
            state     <= RETIRE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (lat_cnt <= LATW'(1)) begin
            c_byte_q <= c_byte;
            z_byte_q <= z_byte;
            state    <= zen_q ? ZREAD : (rmw_q ? CREAD : CWRITE);
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ZREAD: begin
          if (!read_o) begin
            read_o        <= 1'b1;
            render_addr_o <= z_word;
            render_sel_o  <= z_sel;
            render_dat_o  <= '0;
          end else if (ack_i) begin
            read_o <= 1'b0;
            z_old  <= z_rd;
            state  <= ZTEST;
          end
        end
        ZTEST: begin
          if (z_pass) begin
            state <= rmw_q ? CREAD : CWRITE;
          end else begin
            ack_o     <= 1'b1;
            discard_o <= 1'b1;
            state     <= RETIRE;
          end
        end
        CREAD: begin
          if (!read_o) begin
            read_o        <= 1'b1;
            render_addr_o <= c_word;
            render_sel_o  <= lane_sel;
            render_dat_o  <= '0;
          end else if (ack_i) begin
            read_o  <= 1'b0;
            merge_q <= render_dat_i;
            state   <= CWRITE;
          end
        end
        CWRITE: begin
          if (!write_o) begin
            write_o       <= 1'b1;
            render_addr_o <= c_word;
            render_sel_o  <= col_sel;
            render_dat_o  <= col_dat;
          end else if (ack_i) begin
            write_o <= 1'b0;
            if (zen_q) begin
              state <= ZWRITE;
            end else begin
              ack_o <= 1'b1;
              state <= RETIRE;
            end
          end
        end
        ZWRITE: begin
          if (!write_o) begin
            write_o       <= 1'b1;
            render_addr_o <= z_word;
            render_sel_o  <= z_sel;
            render_dat_o  <= z_dat;
          end else if (ack_i) begin
            write_o <= 1'b0;
            ack_o   <= 1'b1;
            state   <= RETIRE;
          end
        end
        RETIRE: begin
          ack_o     <= 1'b0;
          discard_o <= 1'b0;
          state     <= (count != '0) ? POP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_renderer_zq.sv
// Directed bench for gfx_renderer_zq with a byte-lane memory model that acks
// every request one cycle after it appears and logs each transaction.
module tb_gfx_renderer_zq;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  target_base_i, zbuffer_base_i;
  logic [15:0]  target_size_x_i, target_size_y_i;
  logic [5:0]   bpp_i, cbpp_i;
  logic [15:0]  coeff1_i;
  logic [9:0]   coeff2_i;
  logic         rmw_i, zbuffer_enable_i;
  logic [1:0]   zfunc_i;
  logic [15:0]  pixel_x_i, pixel_y_i, pixel_z_i;
  logic [31:0]  color_i;
  logic         write_i;
  logic         full_o;
  logic [31:0]  render_addr_o;
  logic [31:0]  render_sel_o;
  logic [255:0] render_dat_o;
  logic [255:0] render_dat_i;
  logic         read_o, write_o, ack_i, ack_o, discard_o, busy_o;

  gfx_renderer_zq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .target_base_i(target_base_i), .zbuffer_base_i(zbuffer_base_i),
    .target_size_x_i(target_size_x_i), .target_size_y_i(target_size_y_i),
    .bpp_i(bpp_i), .cbpp_i(cbpp_i), .coeff1_i(coeff1_i), .coeff2_i(coeff2_i),
    .rmw_i(rmw_i), .zbuffer_enable_i(zbuffer_enable_i), .zfunc_i(zfunc_i),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
    .color_i(color_i), .write_i(write_i), .full_o(full_o),
    .render_addr_o(render_addr_o), .render_sel_o(render_sel_o),
    .render_dat_o(render_dat_o), .render_dat_i(render_dat_i),
    .read_o(read_o), .write_o(write_o), .ack_i(ack_i),
    .ack_o(ack_o), .discard_o(discard_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         w;
    logic [31:0]  addr;
    logic [31:0]  sel;
    logic [255:0] dat;
  } tr_t;

  tr_t          trq[$];
  logic [255:0] mem [logic [31:0]];

  int n_total = 0, n_bad = 0;
  int n_ack = 0, n_disc = 0, n_disc_lone = 0, n_req = 0;
  logic ack_en = 1'b1;
  int stray_cnt = 0, preset_cnt = 0;
  logic [31:0]  preset_addr = '0;
  logic [255:0] preset_val = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic tr_t tr_at(input int idx);
    tr_t t;
    t = '0;
    if (idx >= 0 && idx < trq.size()) t = trq[idx];
    return t;
  endfunction

  // memory model / bus responder
  initial begin
    tr_t t;
    logic [255:0] word;
    int stray_seen, preset_seen;
    ack_i = 1'b0;
    render_dat_i = '0;
    stray_seen = 0;
    preset_seen = 0;
    forever begin
      @(posedge clk_i); #1;
      if (preset_cnt != preset_seen) begin
        mem[preset_addr] = preset_val;
        preset_seen = preset_cnt;
      end
      if (ack_i) begin
        ack_i = 1'b0;
      end else if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        ack_i = 1'b1;
      end else if ((read_o || write_o) && ack_en) begin
        t.w = write_o; t.addr = render_addr_o; t.sel = render_sel_o; t.dat = render_dat_o;
        trq.push_back(t);
        word = mem.exists(render_addr_o) ? mem[render_addr_o] : '0;
        if (write_o) begin
          for (int b = 0; b < 32; b++)
            if (render_sel_o[b]) word[b*8 +: 8] = render_dat_o[b*8 +: 8];
          mem[render_addr_o] = word;
        end else begin
          render_dat_i = word;
        end
        ack_i = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (ack_o) n_ack++;
      if (discard_o) n_disc++;
      if (discard_o && !ack_o) n_disc_lone++;
      if (read_o || write_o) n_req++;
    end
  end

  task automatic preset(input logic [31:0] a, input logic [255:0] v);
    preset_addr = a;
    preset_val  = v;
    preset_cnt++;
    @(posedge clk_i); #2;
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      input logic [31:0] c);
    pixel_x_i = x; pixel_y_i = y; pixel_z_i = z; color_i = c;
    write_i = 1'b1;
    @(posedge clk_i); #1;
    write_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (!busy_o) break;
    end
    chk(tag, busy_o, 0);
  endtask

  initial begin
    int b, a0, d0, r0, first_full;
    logic [255:0] e;
    rst_i = 1'b1; write_i = 1'b0;
    target_base_i = 32'h1000_0000; zbuffer_base_i = 32'h2000_0000;
    target_size_x_i = 16'd100; target_size_y_i = 16'd100;
    bpp_i = 6'd32; cbpp_i = 6'd32; coeff1_i = 16'd400; coeff2_i = 10'd100;
    rmw_i = 1'b0; zbuffer_enable_i = 1'b0; zfunc_i = 2'd3;
    pixel_x_i = '0; pixel_y_i = '0; pixel_z_i = '0; color_i = '0;
    repeat (3) @(posedge clk_i); #1;
    chk("reset_outs", {read_o, write_o, ack_o, discard_o, full_o, busy_o}, 0);
    chk("reset_addr", render_addr_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // plain write, zbuffer off (zfunc NEVER must not matter)
    b = trq.size(); a0 = n_ack; d0 = n_disc;
    push(16'd10, 16'd20, 16'd0, 32'h00FF_00FF);
    wait_idle("t1_idle");
    chk("t1_count", trq.size() - b, 1);
    chk("t1_req", {tr_at(b).w, tr_at(b).addr, tr_at(b).sel}, {1'b1, 32'h1000_1F60, 32'h0000_0F00});
    e = 256'h00FF_00FF << 64;
    chk("t1_dat", tr_at(b).dat, e);
    chk("t1_ack", n_ack - a0, 1);
    chk("t1_disc", n_disc - d0, 0);

    // clipping at x and y boundaries, plus last valid pixel
    b = trq.size(); a0 = n_ack; d0 = n_disc; r0 = n_req;
    push(16'd100, 16'd5, 16'd0, 32'h1111_1111);
    wait_idle("t2a_idle");
    chk("t2_clip_req", n_req - r0, 0);
    push(16'd5, 16'd100, 16'd0, 32'h2222_2222);
    push(16'd99, 16'd99, 16'd0, 32'h3333_3333);
    wait_idle("t2b_idle");
    chk("t2_ack", n_ack - a0, 3);
    chk("t2_disc", n_disc - d0, 2);
    chk("t2_count", trq.size() - b, 1);
    chk("t2_edge_req", {tr_at(b).w, tr_at(b).addr, tr_at(b).sel}, {1'b1, 32'h1000_9C20, 32'hF000_0000});
    e = 256'h3333_3333 << 224;
    chk("t2_edge_dat", tr_at(b).dat, e);

    // depth test LESS, pass
    zbuffer_enable_i = 1'b1; zfunc_i = 2'd0;
    preset(32'h2000_0180, 256'h0100 << 176);
    b = trq.size(); d0 = n_disc;
    push(16'd3, 16'd2, 16'h00FF, 32'hCAFE_BABE);
    wait_idle("t3a_idle");
    chk("t3a_count", trq.size() - b, 3);
    chk("t3a_zrd", {tr_at(b).w, tr_at(b).addr, tr_at(b).sel}, {1'b0, 32'h2000_0180, 32'h00C0_0000});
    chk("t3a_cwr", {tr_at(b+1).w, tr_at(b+1).addr, tr_at(b+1).sel}, {1'b1, 32'h1000_0320, 32'h0000_F000});
    e = 256'hCAFE_BABE << 96;
    chk("t3a_cdat", tr_at(b+1).dat, e);
    chk("t3a_zwr", {tr_at(b+2).w, tr_at(b+2).addr, tr_at(b+2).sel}, {1'b1, 32'h2000_0180, 32'h00C0_0000});
    e = 256'h00FF << 176;
    chk("t3a_zdat", tr_at(b+2).dat, e);
    chk("t3a_disc", n_disc - d0, 0);

    // LESS with equal z fails
    preset(32'h2000_0180, 256'h0100 << 176);
    b = trq.size(); d0 = n_disc;
    push(16'd3, 16'd2, 16'h0100, 32'h1234_5678);
    wait_idle("t3b_idle");
    chk("t3b_count", trq.size() - b, 1);
    chk("t3b_kind", tr_at(b).w, 0);
    chk("t3b_disc", n_disc - d0, 1);

    // LEQUAL with equal z passes
    zfunc_i = 2'd1;
    preset(32'h2000_0180, 256'h0100 << 176);
    b = trq.size(); d0 = n_disc;
    push(16'd3, 16'd2, 16'h0100, 32'h1234_5678);
    wait_idle("t3c_idle");
    chk("t3c_count", trq.size() - b, 3);
    e = 256'h1234_5678 << 96;
    chk("t3c_cdat", tr_at(b+1).dat, e);
    e = 256'h0100 << 176;
    chk("t3c_zdat", tr_at(b+2).dat, e);
    chk("t3c_disc", n_disc - d0, 0);

    // FIFO fill with bus stalled
    zbuffer_enable_i = 1'b0; zfunc_i = 2'd2; ack_en = 1'b0;
    b = trq.size(); a0 = n_ack; first_full = -1;
    for (int i = 0; i < 10; i++) begin
      pixel_x_i = 16'(i); pixel_y_i = 16'd0; pixel_z_i = 16'd0; color_i = 32'h100 + 32'(i);
      write_i = 1'b1;
      @(posedge clk_i); #1;
      if (full_o && first_full < 0) first_full = i;
    end
    write_i = 1'b0;
    chk("t4_full_at", first_full, 8);
    chk("t4_full", full_o, 1);
    ack_en = 1'b1;
    wait_idle("t4_idle");
    chk("t4_count", trq.size() - b, 9);
    chk("t4_acks", n_ack - a0, 9);
    chk("t4_full_clr", full_o, 0);
    for (int i = 0; i < 9; i++) begin
      e = 256'(32'h100 + 32'(i)) << (32 * (i % 8));
      chk("t4_order", tr_at(b + i).dat, e);
    end

    // read-modify-write, 8 bpp, byte 1
    bpp_i = 6'd8; cbpp_i = 6'd8; coeff1_i = 16'd100; rmw_i = 1'b1;
    preset(32'h1000_0000, 256'h1122_3344);
    b = trq.size();
    push(16'd1, 16'd0, 16'd0, 32'h5566_77AA);
    wait_idle("t5_idle");
    chk("t5_count", trq.size() - b, 2);
    chk("t5_rd", {tr_at(b).w, tr_at(b).addr, tr_at(b).sel}, {1'b0, 32'h1000_0000, 32'h0000_000F});
    chk("t5_wr", {tr_at(b+1).w, tr_at(b+1).addr, tr_at(b+1).sel}, {1'b1, 32'h1000_0000, 32'h0000_000F});
    chk("t5_dat", tr_at(b+1).dat, 256'h1122_AA44);

    // reset during a stalled colour write
    rmw_i = 1'b0; bpp_i = 6'd32; cbpp_i = 6'd32; coeff1_i = 16'd400; ack_en = 1'b0;
    push(16'd1, 16'd1, 16'd0, 32'hA1);
    push(16'd2, 16'd2, 16'd0, 32'hA2);
    push(16'd3, 16'd3, 16'd0, 32'hA3);
    for (int i = 0; i < 50; i++) begin
      if (write_o) break;
      @(posedge clk_i); #1;
    end
    chk("t6_req", write_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("t6_rst_outs", {write_o, read_o, busy_o, full_o, ack_o}, 0);
    rst_i = 1'b0;
    a0 = n_ack;
    stray_cnt++;
    repeat (10) @(posedge clk_i);
    #1;
    chk("t6_no_ack", n_ack - a0, 0);
    chk("t6_busy", busy_o, 0);

    chk("disc_alone", n_disc_lone, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
